// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite register test master.
//   RESP_*    : AXI response encodings
//   LFSR_TAPS : Galois feedback mask for the 32-bit pattern generator
//   state_e   : sequencing states of the test master
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WR_RESP,
    ST_RD,
    ST_RD_DATA,
    ST_NEXT,
    ST_FIN
  } state_e;

endpackage

// File: rtl/lfsr32_galois.sv
// 32-bit right-shifting Galois LFSR used as the test pattern source.
//   ACLK, ARESETN : clock, async active-low reset (state resets to 0)
//   load          : load seed (a zero seed is replaced by 1); has priority over step
//   seed          : seed value
//   step          : advance one position
//   q             : current LFSR value
module lfsr32_galois
  import axi_lite_pkg::*;
(
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] q
);

  logic [31:0] q_q;
  logic [31:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = (seed == '0) ? 32'h1 : seed;
    end else if (step) begin
      q_d = {1'b0, q_q[31:1]} ^ (q_q[0] ? LFSR_TAPS : '0);
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/axi_lite_reg_test_master.sv
// AXI4-Lite master that writes NUM_REGS LFSR patterns from BASE_ADDR, reads
// them back and compares, counting response/data errors with a per-handshake
// timeout.
//   ACLK, ARESETN   : clock, async active-low reset
//   start/mode/seed : run request (sampled in IDLE), ordering mode, LFSR seed
//   m_axi_*         : AXI4-Lite master channels AW, W, B, AR, R
//   busy, done      : run in progress, one-cycle end-of-run pulse
//   pass, timeout   : result of last run (held until next start)
//   err_count       : saturating error count of last run
//   first_err_addr  : address of first error of last run, 0 if none
module axi_lite_reg_test_master
  import axi_lite_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter int unsigned           NUM_REGS       = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int unsigned           ADDR_STRIDE    = DATA_WIDTH / 8,
  parameter int unsigned           TIMEOUT_CYCLES = 1024,
  parameter bit                    STOP_ON_ERR    = 1'b0
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    start,
  input  logic                    mode,
  input  logic [31:0]             seed,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    timeout,
  output logic [15:0]             err_count,
  output logic [ADDR_WIDTH-1:0]   first_err_addr
);

  localparam logic [8:0]            LAST_IDX = 9'(NUM_REGS - 1);
  localparam logic [31:0]           TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] STRIDE   = ADDR_WIDTH'(ADDR_STRIDE);

  state_e                  state_q, state_d;
  logic [8:0]              idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             seed_q, seed_d;
  logic                    mode_q, mode_d;
  logic                    rd_phase_q, rd_phase_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic [15:0]             err_count_q, err_count_d;
  logic [ADDR_WIDTH-1:0]   first_err_addr_q, first_err_addr_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    pass_q, pass_d;
  logic                    timeout_q, timeout_d;
  logic [31:0]             tmo_cnt_q, tmo_cnt_d;

  logic                    lfsr_load;
  logic                    lfsr_step;
  logic [31:0]             lfsr_seed;
  logic [31:0]             lfsr_q;
  logic [DATA_WIDTH-1:0]   pattern;
  logic                    beat_err;
  logic                    is_last;
  logic                    wait_state;

  // The live seed is only used when a run starts; a mode-1 rewind reuses the
  // seed captured at that start.
  assign lfsr_seed = (state_q == ST_IDLE) ? seed : seed_q;

  lfsr32_galois u_lfsr (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .load    (lfsr_load),
    .seed    (lfsr_seed),
    .step    (lfsr_step),
    .q       (lfsr_q)
  );

  assign pattern    = {(DATA_WIDTH / 32){lfsr_q}};
  assign is_last    = (idx_q == LAST_IDX);
  assign wait_state = (state_q inside {ST_WR, ST_WR_RESP, ST_RD, ST_RD_DATA});

  assign m_axi_awaddr  = addr_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_wdata   = pattern;
  assign m_axi_awprot  = '0;
  assign m_axi_arprot  = '0;
  assign m_axi_wstrb   = '1;
  assign m_axi_awvalid = (state_q == ST_WR) && !aw_done_q;
  assign m_axi_wvalid  = (state_q == ST_WR) && !w_done_q;
  assign m_axi_bready  = (state_q == ST_WR_RESP);
  assign m_axi_arvalid = (state_q == ST_RD);
  assign m_axi_rready  = (state_q == ST_RD_DATA);

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign timeout        = timeout_q;
  assign err_count      = err_count_q;
  assign first_err_addr = first_err_addr_q;

  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    addr_d           = addr_q;
    seed_d           = seed_q;
    mode_d           = mode_q;
    rd_phase_d       = rd_phase_q;
    aw_done_d        = aw_done_q;
    w_done_d         = w_done_q;
    err_count_d      = err_count_q;
    first_err_addr_d = first_err_addr_q;
    busy_d           = busy_q;
    done_d           = 1'b0;
    pass_d           = pass_q;
    timeout_d        = timeout_q;
    tmo_cnt_d        = '0;
    lfsr_load        = 1'b0;
    lfsr_step        = 1'b0;
    beat_err         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d          = ST_WR;
          idx_d            = '0;
          addr_d           = BASE_ADDR;
          seed_d           = seed;
          mode_d           = mode;
          rd_phase_d       = 1'b0;
          lfsr_load        = 1'b1;
          err_count_d      = '0;
          first_err_addr_d = '0;
          pass_d           = 1'b0;
          timeout_d        = 1'b0;
          busy_d           = 1'b1;
        end
      end
      ST_WR: begin
        aw_done_d = aw_done_q | (m_axi_awvalid & m_axi_awready);
        w_done_d  = w_done_q | (m_axi_wvalid & m_axi_wready);
        if (aw_done_d && w_done_d) begin
          state_d   = ST_WR_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      ST_WR_RESP: begin
        if (m_axi_bvalid) begin
          beat_err = (m_axi_bresp != RESP_OKAY);
          if (!mode_q) begin
            state_d = ST_RD;
          end else if (is_last) begin
            state_d    = ST_RD;
            idx_d      = '0;
            addr_d     = BASE_ADDR;
            rd_phase_d = 1'b1;
            lfsr_load  = 1'b1;
          end else begin
            state_d = ST_NEXT;
          end
        end
      end
      ST_RD: begin
        if (m_axi_arready) begin
          state_d = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (m_axi_rvalid) begin
          beat_err = (m_axi_rresp != RESP_OKAY) || (m_axi_rdata != pattern);
          state_d  = is_last ? ST_FIN : ST_NEXT;
        end
      end
      ST_NEXT: begin
        idx_d     = idx_q + 9'd1;
        addr_d    = addr_q + STRIDE;
        lfsr_step = 1'b1;
        state_d   = (mode_q && rd_phase_q) ? ST_RD : ST_WR;
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (beat_err) begin
      if (err_count_q != 16'hFFFF) begin
        err_count_d = err_count_q + 16'd1;
      end
      if (err_count_q == '0) begin
        first_err_addr_d = addr_q;
      end
      if (STOP_ON_ERR) begin
        state_d = ST_FIN;
      end
    end

    // A handshake completing in the last allowed cycle still wins; only a
    // wait that would extend past the limit is aborted.
    if (wait_state && (state_d == state_q)) begin
      if (tmo_cnt_q >= TMO_LAST) begin
        state_d   = ST_FIN;
        timeout_d = 1'b1;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 32'd1;
      end
    end

    if ((state_d == ST_FIN) && (state_q != ST_FIN)) begin
      done_d = 1'b1;
      busy_d = 1'b0;
      pass_d = !timeout_d && (err_count_d == '0);
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q          <= ST_IDLE;
      idx_q            <= '0;
      addr_q           <= '0;
      seed_q           <= '0;
      mode_q           <= 1'b0;
      rd_phase_q       <= 1'b0;
      aw_done_q        <= 1'b0;
      w_done_q         <= 1'b0;
      err_count_q      <= '0;
      first_err_addr_q <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      timeout_q        <= 1'b0;
      tmo_cnt_q        <= '0;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      addr_q           <= addr_d;
      seed_q           <= seed_d;
      mode_q           <= mode_d;
      rd_phase_q       <= rd_phase_d;
      aw_done_q        <= aw_done_d;
      w_done_q         <= w_done_d;
      err_count_q      <= err_count_d;
      first_err_addr_q <= first_err_addr_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      pass_q           <= pass_d;
      timeout_q        <= timeout_d;
      tmo_cnt_q        <= tmo_cnt_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_test_master.sv
// Self-checking bench: drives the test master against an AXI-Lite RAM slave
// with configurable ready skews and fault injection, and compares each run
// with a transaction-level reference model.
module tb_axi_lite_reg_test_master;

  localparam logic [31:0] TAPS  = 32'h8020_0003;
  localparam int unsigned NREGS = 4;

  typedef struct {
    bit          rd;
    logic [31:0] addr;
    logic [31:0] data;
  } op_t;

  logic ACLK    = 1'b0;
  logic ARESETN = 1'b1;
  always #5 ACLK = ~ACLK;

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // stimulus / selection
  logic        sel = 1'b0;
  logic        start = 1'b0;
  logic        mode_i = 1'b0;
  logic [31:0] seed_i = '0;

  // slave-driven signals
  logic        s_awready = 0, s_wready = 0, s_bvalid = 0, s_arready = 0, s_rvalid = 0;
  logic [1:0]  s_bresp = 0, s_rresp = 0;
  logic [31:0] s_rdata = 0;

  // DUT outputs: a_* = STOP_ON_ERR 0, b_* = STOP_ON_ERR 1
  logic [31:0] a_awaddr, a_wdata, a_araddr, a_first, b_awaddr, b_wdata, b_araddr, b_first;
  logic [2:0]  a_awprot, a_arprot, b_awprot, b_arprot;
  logic [3:0]  a_wstrb, b_wstrb;
  logic        a_awvalid, a_wvalid, a_bready, a_arvalid, a_rready;
  logic        b_awvalid, b_wvalid, b_bready, b_arvalid, b_rready;
  logic        a_busy, a_done, a_pass, a_timeout, b_busy, b_done, b_pass, b_timeout;
  logic [15:0] a_err, b_err;

  // selected master as seen by the slave and checks
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_first;
  logic [2:0]  m_awprot, m_arprot;
  logic [3:0]  m_wstrb;
  logic        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic        m_busy, m_done, m_pass, m_timeout;
  logic [15:0] m_err;

  assign m_awaddr  = sel ? b_awaddr  : a_awaddr;
  assign m_wdata   = sel ? b_wdata   : a_wdata;
  assign m_araddr  = sel ? b_araddr  : a_araddr;
  assign m_first   = sel ? b_first   : a_first;
  assign m_awprot  = sel ? b_awprot  : a_awprot;
  assign m_arprot  = sel ? b_arprot  : a_arprot;
  assign m_wstrb   = sel ? b_wstrb   : a_wstrb;
  assign m_awvalid = sel ? b_awvalid : a_awvalid;
  assign m_wvalid  = sel ? b_wvalid  : a_wvalid;
  assign m_bready  = sel ? b_bready  : a_bready;
  assign m_arvalid = sel ? b_arvalid : a_arvalid;
  assign m_rready  = sel ? b_rready  : a_rready;
  assign m_busy    = sel ? b_busy    : a_busy;
  assign m_done    = sel ? b_done    : a_done;
  assign m_pass    = sel ? b_pass    : a_pass;
  assign m_timeout = sel ? b_timeout : a_timeout;
  assign m_err     = sel ? b_err     : a_err;

  axi_lite_reg_test_master #(.NUM_REGS(NREGS), .TIMEOUT_CYCLES(1024), .STOP_ON_ERR(1'b0)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start & ~sel), .mode(mode_i), .seed(seed_i),
    .m_axi_awaddr(a_awaddr), .m_axi_awprot(a_awprot), .m_axi_awvalid(a_awvalid),
    .m_axi_awready(s_awready & ~sel),
    .m_axi_wdata(a_wdata), .m_axi_wstrb(a_wstrb), .m_axi_wvalid(a_wvalid),
    .m_axi_wready(s_wready & ~sel),
    .m_axi_bresp(s_bresp), .m_axi_bvalid(s_bvalid & ~sel), .m_axi_bready(a_bready),
    .m_axi_araddr(a_araddr), .m_axi_arprot(a_arprot), .m_axi_arvalid(a_arvalid),
    .m_axi_arready(s_arready & ~sel),
    .m_axi_rdata(s_rdata), .m_axi_rresp(s_rresp), .m_axi_rvalid(s_rvalid & ~sel),
    .m_axi_rready(a_rready),
    .busy(a_busy), .done(a_done), .pass(a_pass), .timeout(a_timeout),
    .err_count(a_err), .first_err_addr(a_first)
  );

  axi_lite_reg_test_master #(.NUM_REGS(NREGS), .TIMEOUT_CYCLES(1024), .STOP_ON_ERR(1'b1)) dut_stop (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start & sel), .mode(mode_i), .seed(seed_i),
    .m_axi_awaddr(b_awaddr), .m_axi_awprot(b_awprot), .m_axi_awvalid(b_awvalid),
    .m_axi_awready(s_awready & sel),
    .m_axi_wdata(b_wdata), .m_axi_wstrb(b_wstrb), .m_axi_wvalid(b_wvalid),
    .m_axi_wready(s_wready & sel),
    .m_axi_bresp(s_bresp), .m_axi_bvalid(s_bvalid & sel), .m_axi_bready(b_bready),
    .m_axi_araddr(b_araddr), .m_axi_arprot(b_arprot), .m_axi_arvalid(b_arvalid),
    .m_axi_arready(s_arready & sel),
    .m_axi_rdata(s_rdata), .m_axi_rresp(s_rresp), .m_axi_rvalid(s_rvalid & sel),
    .m_axi_rready(b_rready),
    .busy(b_busy), .done(b_done), .pass(b_pass), .timeout(b_timeout),
    .err_count(b_err), .first_err_addr(b_first)
  );

  // ---------------- slave model ----------------
  logic [31:0] mem [logic [31:0]];
  int unsigned aw_min = 0, aw_max = 0, w_max = 0, ar_max = 0;
  bit          aw_block = 0, flip_en = 0, slverr_en = 0;
  logic [31:0] flip_addr = 0, slverr_addr = 0;

  bit          aw_fire, w_fire, b_fire, ar_fire, r_fire, have_aw, have_w;
  logic [31:0] aw_a, w_d, ar_a, bw_a, bw_d;
  int unsigned aw_wait, w_wait, ar_wait, aw_dly, w_dly, ar_dly;
  bit          p_aw, p_w, p_ar;
  logic [31:0] p_awaddr, p_wdata, p_araddr;

  op_t         log_q[$];
  int unsigned n_aw, n_w, n_b, n_ar, n_r, stab_viol, side_viol;

  task automatic slave_reset();
    s_awready = 0; s_wready = 0; s_bvalid = 0; s_arready = 0; s_rvalid = 0;
    s_bresp = 0; s_rresp = 0; s_rdata = 0;
    aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
    have_aw = 0; have_w = 0; aw_wait = 0; w_wait = 0; ar_wait = 0;
    p_aw = 0; p_w = 0; p_ar = 0;
  endtask

  initial begin : slave
    slave_reset();
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        slave_reset();
      end else begin
        // a pending valid may only disappear through a handshake or an abort
        if (p_aw && (!m_awvalid || m_awaddr != p_awaddr) && !m_done) stab_viol++;
        if (p_w && (!m_wvalid || m_wdata != p_wdata) && !m_done) stab_viol++;
        if (p_ar && (!m_arvalid || m_araddr != p_araddr) && !m_done) stab_viol++;
        // effects of handshakes taken at the preceding rising edge
        if (b_fire) s_bvalid = 0;
        if (r_fire) s_rvalid = 0;
        if (aw_fire) have_aw = 1;
        if (w_fire) have_w = 1;
        if (have_aw && have_w && !s_bvalid) begin
          if (slverr_en && aw_a == slverr_addr) s_bresp = 2'b10;
          else begin s_bresp = 2'b00; mem[aw_a] = w_d; end
          bw_a = aw_a; bw_d = w_d;
          s_bvalid = 1; have_aw = 0; have_w = 0;
        end
        if (ar_fire) begin
          s_rvalid = 1; s_rresp = 2'b00;
          s_rdata = mem.exists(ar_a) ? mem[ar_a] : 32'h0;
          if (flip_en && ar_a == flip_addr) s_rdata[0] = ~s_rdata[0];
        end
        // readiness for the coming edge
        s_awready = m_awvalid && !have_aw && !aw_block && (aw_wait >= aw_dly);
        if (m_awvalid && !s_awready) aw_wait++;
        s_wready = m_wvalid && !have_w && (w_wait >= w_dly);
        if (m_wvalid && !s_wready) w_wait++;
        s_arready = m_arvalid && !s_rvalid && (ar_wait >= ar_dly);
        if (m_arvalid && !s_arready) ar_wait++;
        // handshakes that will happen at the coming edge
        aw_fire = m_awvalid && s_awready;
        w_fire  = m_wvalid && s_wready;
        b_fire  = s_bvalid && m_bready;
        ar_fire = m_arvalid && s_arready;
        r_fire  = s_rvalid && m_rready;
        if (aw_fire) begin
          aw_a = m_awaddr; n_aw++; aw_wait = 0; aw_dly = $urandom_range(aw_max, aw_min);
          if (m_awprot != 3'b000) side_viol++;
        end
        if (w_fire) begin
          w_d = m_wdata; n_w++; w_wait = 0; w_dly = $urandom_range(w_max, 0);
          if (m_wstrb != 4'hF) side_viol++;
        end
        if (b_fire) begin
          n_b++;
          log_q.push_back('{rd: 1'b0, addr: bw_a, data: bw_d});
        end
        if (ar_fire) begin
          n_ar++; ar_a = m_araddr; ar_wait = 0; ar_dly = $urandom_range(ar_max, 0);
          if (m_arprot != 3'b000) side_viol++;
          log_q.push_back('{rd: 1'b1, addr: m_araddr, data: 32'h0});
        end
        if (r_fire) n_r++;
        p_aw = m_awvalid && !aw_fire; p_awaddr = m_awaddr;
        p_w  = m_wvalid && !w_fire;   p_wdata  = m_wdata;
        p_ar = m_arvalid && !ar_fire; p_araddr = m_araddr;
      end
    end
  end

  // ---------------- reference model ----------------
  op_t         exp_q[$];
  int unsigned exp_err;
  logic [31:0] exp_first;

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? TAPS : 32'h0);
  endfunction

  task automatic model(input bit md, input logic [31:0] sd, input bit stop);
    logic [31:0] pat [NREGS];
    logic [31:0] s;
    int unsigned order_rd [2*NREGS];
    int unsigned order_ix [2*NREGS];
    bit          err;
    logic [31:0] a;
    s = (sd == 0) ? 32'h1 : sd;
    for (int unsigned i = 0; i < NREGS; i++) begin
      pat[i] = s;
      s = lfsr_next(s);
    end
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (!md) begin
        order_rd[2*i] = 0; order_ix[2*i] = i; order_rd[2*i+1] = 1; order_ix[2*i+1] = i;
      end else begin
        order_rd[i] = 0; order_ix[i] = i; order_rd[NREGS+i] = 1; order_ix[NREGS+i] = i;
      end
    end
    exp_q.delete(); exp_err = 0; exp_first = 0;
    for (int unsigned k = 0; k < 2*NREGS; k++) begin
      a = order_ix[k] * 4;
      if (order_rd[k] == 0) err = slverr_en && a == slverr_addr;
      else err = (flip_en && a == flip_addr) || (slverr_en && a == slverr_addr);
      exp_q.push_back('{rd: order_rd[k] != 0, addr: a, data: (order_rd[k] != 0) ? 32'h0 : pat[order_ix[k]]});
      if (err) begin
        exp_err++;
        if (exp_err == 1) exp_first = a;
        if (stop) break;
      end
    end
  endtask

  // ---------------- run helpers ----------------
  task automatic clear_log();
    log_q.delete();
    n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0; stab_viol = 0; side_viol = 0;
    aw_dly = $urandom_range(aw_max, aw_min); w_dly = $urandom_range(w_max, 0);
    ar_dly = $urandom_range(ar_max, 0);
  endtask

  task automatic launch(input bit use_b, input bit md, input logic [31:0] sd);
    sel = use_b; mode_i = md; seed_i = sd;
    clear_log();
    @(negedge ACLK); start = 1;
    @(negedge ACLK); start = 0;
  endtask

  task automatic wait_done(input string tag, input int unsigned budget);
    bit seen = 0;
    for (int unsigned c = 0; c < budget; c++) begin
      if (m_done) begin seen = 1; break; end
      @(negedge ACLK);
    end
    check_eq({tag, "_done_seen"}, seen, 1);
  endtask

  task automatic run_and_check(input string tag, input bit use_b, input bit md, input logic [31:0] sd);
    model(md, sd, use_b);
    launch(use_b, md, sd);
    wait_done(tag, 5000);
    check_eq({tag, "_err_count"}, m_err, exp_err);
    check_eq({tag, "_first_err"}, m_first, exp_first);
    check_eq({tag, "_pass"}, m_pass, exp_err == 0);
    check_eq({tag, "_timeout"}, m_timeout, 0);
    check_eq({tag, "_busy_at_done"}, m_busy, 0);
    check_eq({tag, "_n_ops"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      check_eq($sformatf("%s_op%0d_kind", tag, i), log_q[i].rd, exp_q[i].rd);
      check_eq($sformatf("%s_op%0d_addr", tag, i), log_q[i].addr, exp_q[i].addr);
      check_eq($sformatf("%s_op%0d_data", tag, i), log_q[i].data, exp_q[i].data);
    end
    check_eq({tag, "_aw_eq_b"}, n_aw, n_b);
    check_eq({tag, "_w_eq_b"}, n_w, n_b);
    check_eq({tag, "_r_eq_ar"}, n_r, n_ar);
    check_eq({tag, "_stability"}, stab_viol, 0);
    check_eq({tag, "_prot_strb"}, side_viol, 0);
    @(negedge ACLK);
    check_eq({tag, "_done_pulse"}, m_done, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ctrl"}, {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready,
                              m_busy, m_done, m_pass, m_timeout}, 9'h0);
    check_eq({tag, "_err_count"}, m_err, 0);
    check_eq({tag, "_first_err"}, m_first, 0);
    check_eq({tag, "_addr_data"}, {m_awaddr, m_wdata}, 64'h0);
  endtask

  task automatic reset_pulse();
    @(negedge ACLK); ARESETN = 0;
    repeat (2) @(negedge ACLK);
    ARESETN = 1;
    @(negedge ACLK);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int unsigned aw_cycles;
    bit          seen;
    #2 ARESETN = 0;
    repeat (3) @(negedge ACLK);
    check_reset_outputs("reset");
    ARESETN = 1;
    @(negedge ACLK);

    // 1: clean mode-0 run, zero-wait slave
    run_and_check("t1", 0, 0, 32'h0101FFFF);
    check_eq("t1_n_b", n_b, 4);
    check_eq("t1_n_r", n_r, 4);

    // 2: bit 0 of register 2 corrupted on readback
    flip_en = 1; flip_addr = 32'h8;
    run_and_check("t2", 0, 0, 32'h0101FFFF);
    check_eq("t2_first_err_addr", m_first, 32'h8);
    flip_en = 0;

    // 3: SLVERR on register 1 write, stop on first error
    slverr_en = 1; slverr_addr = 32'h4;
    run_and_check("t3", 1, 1, 32'h1234_5678);
    check_eq("t3_no_ar", n_ar, 0);
    check_eq("t3_n_b", n_b, 2);
    slverr_en = 0;

    // 4: AW never accepted -> timeout after 1024 cycles of awvalid
    aw_block = 1;
    launch(0, 0, 32'hCAFE_0001);
    aw_cycles = 0; seen = 0;
    for (int unsigned c = 0; c < 3000; c++) begin
      if (m_done) begin seen = 1; break; end
      if (m_awvalid) aw_cycles++;
      @(negedge ACLK);
    end
    check_eq("t4_done_seen", seen, 1);
    check_eq("t4_awvalid_cycles", aw_cycles, 1024);
    check_eq("t4_timeout", m_timeout, 1);
    check_eq("t4_pass", m_pass, 0);
    check_eq("t4_valids_low", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 5'h0);
    aw_block = 0;
    reset_pulse();

    // 5: mode 1 with zero seed
    run_and_check("t5", 0, 1, 32'h0);
    if (log_q.size() > NREGS) begin
      check_eq("t5_first_wdata", log_q[0].data, 32'h1);
      check_eq("t5_first_read_pos", log_q[NREGS].rd, 1);
    end else begin
      check_eq("t5_log_len", log_q.size(), 2 * NREGS);
    end

    // randomized runs
    aw_max = 5; w_max = 5; ar_max = 3;
    for (int r = 0; r < 10; r++) begin
      flip_en = ($urandom_range(1, 0) != 0);
      flip_addr = 4 * $urandom_range(NREGS - 1, 0);
      run_and_check($sformatf("rnd%0d", r), 0, $urandom_range(1, 0) != 0,
                    ($urandom_range(3, 0) == 0) ? 32'h0 : $urandom);
    end
    flip_en = 0;

    // 6: wready ahead of awready, then reset in the middle of a read beat
    aw_min = 1; aw_max = 5; w_max = 0;
    launch(0, 0, 32'h5A5A_0F0F);
    seen = 0;
    for (int unsigned c = 0; c < 500; c++) begin
      if (m_rready) begin seen = 1; break; end
      @(negedge ACLK);
    end
    check_eq("t6_rd_data_reached", seen, 1);
    check_eq("t6_stability", stab_viol, 0);
    ARESETN = 0;
    #1;
    check_reset_outputs("t6_after_reset");
    @(negedge ACLK);
    ARESETN = 1;
    aw_min = 0; aw_max = 0; w_max = 0; ar_max = 0;
    @(negedge ACLK);
    run_and_check("t6_recover", 0, 0, 32'h0BAD_F00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
